// File: rtl/mem_periph_pkg.sv
// Shared types and default sizing for the byte-write-enable memory peripheral.
// The FSM state enum and the derived widths of the default 32x256 build live here.
package mem_periph_pkg;

  typedef enum logic {
    CLEAR  = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 256;

  localparam int STRB_W = DATA_W_DEF / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH_DEF);

  // A depth of one still needs a one-bit index to keep vectors legal.
  function automatic int safe_clog2(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/mem_sp_ram_bytewe.sv
// Single-port DEPTH x DATA_W array with per-byte write enables and a registered read.
// The array has no reset; contents are zeroed only by the clear engine in the top level.
module mem_sp_ram_bytewe #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic                  clk,
  input  logic [IDX_W-1:0]      addr,
  input  logic [DATA_W/8-1:0]   we,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Read returns the word as it stood before this edge's write.
  always_ff @(posedge clk) begin
    for (int k = 0; k < DATA_W / 8; k++) begin
      if (we[k]) begin
        mem[addr][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_periph_bytewe.sv
// CPU data-bus memory slave: valid/ready requests, one-cycle responses, range errors,
// and a clear engine that zero-fills the array after reset or on clear_start.
module mem_periph_bytewe
  import mem_periph_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_wstrb,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_error,
  input  logic                  clear_start,
  output logic                  busy
);

  localparam int LANES    = DATA_W / 8;
  localparam int OFF_BITS = $clog2(LANES);
  localparam int IDX_BITS = safe_clog2(DEPTH);

  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(DEPTH - 1);

  state_t              state;
  state_t              next_state;
  logic [IDX_BITS-1:0] clr_cnt;
  logic [IDX_BITS-1:0] next_cnt;

  logic [ADDR_W-1:0]   word_idx;
  logic                in_range;
  logic                accept;
  logic                read_hit;

  logic [IDX_BITS-1:0] ram_addr;
  logic [LANES-1:0]    ram_we;
  logic [DATA_W-1:0]   ram_wdata;
  logic [DATA_W-1:0]   ram_rdata;

  // Byte offset bits are simply dropped, so misaligned addresses hit the containing word.
  assign word_idx = req_addr >> OFF_BITS;
  assign in_range = ({1'b0, word_idx} < DEPTH_L);
  assign accept   = req_valid && req_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= next_state;
      clr_cnt <= next_cnt;
    end
  end

  // The clear engine owns the RAM port while in CLEAR; requests are refused until it finishes.
  always_comb begin
    next_state = state;
    next_cnt   = clr_cnt;
    req_ready  = 1'b0;
    busy       = 1'b0;
    ram_addr   = word_idx[IDX_BITS-1:0];
    ram_we     = '0;
    ram_wdata  = req_wdata;
    case (state)
      CLEAR: begin
        busy      = 1'b1;
        ram_addr  = clr_cnt;
        ram_we    = '1;
        ram_wdata = '0;
        next_cnt  = clr_cnt + 1'b1;
        if (clr_cnt == LAST_IDX) begin
          next_state = ACTIVE;
          next_cnt   = '0;
        end
      end
      ACTIVE: begin
        req_ready = 1'b1;
        if (req_valid && req_write && in_range) begin
          ram_we = req_wstrb;
        end
        if (clear_start) begin
          next_state = CLEAR;
          next_cnt   = '0;
        end
      end
      default: begin
        next_state = CLEAR;
        next_cnt   = '0;
      end
    endcase
  end

  mem_sp_ram_bytewe #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_BITS)
  ) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // read_hit gates the RAM output so rdata reads as zero for writes, errors and idle cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      read_hit  <= 1'b0;
    end else begin
      rsp_valid <= accept;
      rsp_error <= accept && !in_range;
      read_hit  <= accept && !req_write && in_range;
    end
  end

  assign rsp_rdata = read_hit ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_periph_bytewe.sv
// Scoreboard bench for mem_periph_bytewe (32x256): directed requests push expected
// responses, a negedge monitor pops and compares them against what the DUT presents.
module tb_mem_periph_bytewe;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        clear_start;
  logic        busy;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;

  mem_periph_bytewe #(
    .DATA_W (32),
    .DEPTH  (256),
    .ADDR_W (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_wstrb   (req_wstrb),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_error   (rsp_error),
    .clear_start (clear_start),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response must match the oldest outstanding expectation, in the right cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_rsp: got rsp_valid=1, expected no response (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        check("rsp_cycle", cyc, e.cyc);
        check("rsp_error", {31'b0, rsp_error}, {31'b0, e.err});
        check("rsp_rdata", rsp_rdata, e.data);
      end
    end else begin
      check("idle_rdata", rsp_rdata, 32'h0);
      check("idle_error", {31'b0, rsp_error}, 32'h0);
    end
  end

  task automatic issue(input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                       input logic [3:0] st, input logic exp_err, input logic [31:0] exp_data,
                       input logic clr = 1'b0);
    req_valid   = 1'b1;
    req_write   = wr;
    req_addr    = addr;
    req_wdata   = wd;
    req_wstrb   = st;
    clear_start = clr;
    check("req_ready", {31'b0, req_ready}, 32'h1);
    @(posedge clk);
    #1;
    exp_q.push_back('{err: exp_err, data: exp_data, cyc: cyc});
    clear_start = 1'b0;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_write = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!req_ready && n < 2000);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},      {31'b0, busy},      32'h1);
    check({tag, "_req_ready"}, {31'b0, req_ready}, 32'h0);
    check({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'h0);
    check({tag, "_rsp_rdata"}, rsp_rdata,          32'h0);
    check({tag, "_rsp_error"}, {31'b0, rsp_error}, 32'h0);
  endtask

  initial begin
    int n;
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_addr    = '0;
    req_wdata   = '0;
    req_wstrb   = '0;
    clear_start = 1'b0;

    // Scenario 1: reset state, full clear length, read of a cleared word.
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    wait_ready(n);
    check("clear_len_after_reset", n, 256);
    check("busy_after_clear", {31'b0, busy}, 32'h0);
    issue(1'b0, 16'h0010, 32'h0, 4'h0, 1'b0, 32'h0000_0000);
    idle();

    // Scenario 2: full-word write, read back, offset ignored.
    issue(1'b1, 16'h0008, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0);
    issue(1'b0, 16'h0008, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEEF);
    idle();
    issue(1'b0, 16'h000B, 32'h0, 4'h0, 1'b0, 32'hDEAD_BEEF);
    idle();

    // Scenario 3: partial strobes keep the unselected bytes.
    issue(1'b1, 16'h0008, 32'h1122_3344, 4'b0101, 1'b0, 32'h0);
    issue(1'b0, 16'h0008, 32'h0, 4'h0, 1'b0, 32'hDE22_BE44);
    idle();

    // Scenario 4: out-of-range write and read, index 0 untouched, back-to-back mix.
    issue(1'b1, 16'h0400, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0);
    issue(1'b0, 16'h0000, 32'h0, 4'h0, 1'b0, 32'h0);
    issue(1'b0, 16'h0400, 32'h0, 4'h0, 1'b1, 32'h0);
    idle();
    issue(1'b0, 16'h0008, 32'h0, 4'h0, 1'b0, 32'hDE22_BE44);
    issue(1'b0, 16'h0400, 32'h0, 4'h0, 1'b1, 32'h0);
    idle();

    // Scenario 5: read alongside clear_start, clear is not restarted by a second pulse.
    issue(1'b0, 16'h0008, 32'h0, 4'h0, 1'b0, 32'hDE22_BE44, 1'b1);
    req_valid = 1'b0;
    check("busy_after_clear_start", {31'b0, busy}, 32'h1);
    n = 0;
    while (busy && n < 2000) begin
      clear_start = (n == 50);
      if (n == 100) check("ready_during_clear", {31'b0, req_ready}, 32'h0);
      @(posedge clk);
      #1;
      n++;
    end
    clear_start = 1'b0;
    check("clear_len_on_command", n, 256);
    issue(1'b0, 16'h0008, 32'h0, 4'h0, 1'b0, 32'h0);
    idle();

    // Scenario 6: reset mid-clear restarts a full clear.
    issue(1'b1, 16'h03FC, 32'hA5A5_A5A5, 4'hF, 1'b0, 32'h0);
    issue(1'b0, 16'h03FC, 32'h0, 4'h0, 1'b0, 32'hA5A5_A5A5);
    idle();
    clear_start = 1'b1;
    @(posedge clk);
    #1;
    clear_start = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_reset_outputs("midclear_reset");
    @(negedge clk);
    reset = 1'b0;
    wait_ready(n);
    check("clear_len_after_midclear_reset", n, 256);
    issue(1'b0, 16'h03FC, 32'h0, 4'h0, 1'b0, 32'h0);
    idle();

    repeat (3) @(posedge clk);
    check("outstanding_responses", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_periph_bytewe.md
# mem_periph_bytewe

Parametrised single-port memory peripheral, the next generation of the CPU-side data RAM. It adds configurable width and depth, byte write strobes, a valid/ready request handshake with a one-cycle response, out-of-range error reporting, and a hardware clear engine. The clear engine zeroes the array after reset or on command, so the array itself needs no reset. It sits on the CPU data bus as a slave.

## Interface
- DATA_W, 32, data width in bits; multiple of 8.
- DEPTH, 256, number of words; index range 0..DEPTH-1.
- ADDR_W, 16, byte-address width.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request can be accepted this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  write data.
- req_wstrb  in  DATA_W/8  byte write enables; bit k covers bits [8k+7:8k].
- rsp_valid  out  1  single-cycle response pulse.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_error  out  1  address out of range; valid with rsp_valid.
- clear_start  in  1  request a full-array zero fill.
- busy  out  1  clear in progress.

## Operation
- Word index = req_addr >> log2(DATA_W/8). Low offset bits are ignored; misaligned addresses are not an error.
- The FSM has two states:
  - CLEAR: writes 0 to index clr_cnt, increments clr_cnt each cycle. req_ready=0, busy=1. Moves to ACTIVE after index DEPTH-1 is written.
  - ACTIVE: req_ready=1, busy=0.
- A request is accepted when req_valid && req_ready.
- Accepted write, in range: for each set wstrb bit, that byte is written; the other bytes are kept. The response has rdata=0 and error=0.
- Accepted write, out of range (index ≥ DEPTH): nothing is written. The response has error=1 and rdata=0.
- Accepted read, in range: rdata = stored word, error=0. Out of range: rdata=0, error=1.
- Every accepted request produces exactly one response. There is no response backpressure.
- clear_start in ACTIVE: the FSM enters CLEAR next cycle with clr_cnt=0. A request accepted in that same cycle still completes and responds normally.
- clear_start while in CLEAR is ignored; the clear does not restart.
- Reset assertion, including mid-clear, forces state CLEAR and clr_cnt=0. The full clear reruns after release.
- Array contents are never reset directly; only the clear engine zeroes them.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, busy=1.

## Timing
- Clear duration is exactly DEPTH cycles. On the first clk edge after reset release, index 0 is written.
- req_ready goes high DEPTH cycles after the first edge following release.
- Response latency is 1: a request accepted on edge N gives rsp_valid=1 with rdata/error in the cycle after edge N, for one cycle only.
- Back-to-back requests are accepted every cycle, so throughput is 1 per cycle. rsp_valid then stays high continuously.
- A read immediately after a write to the same index returns the new data, because the write commits on the accept edge.
- Outside a response cycle, rsp_rdata and rsp_error return to 0.
- clear_start is sampled on clk. busy rises the cycle after the accepting edge.

## Structure
- Package mem_periph_pkg holds:
  - the state enum {CLEAR, ACTIVE};
  - localparams STRB_W = DATA_W/8, OFF_W = $clog2(STRB_W), IDX_W = $clog2(DEPTH).
- Sub-module mem_sp_ram_bytewe: a single-port DEPTH×DATA_W array with per-byte write enables and a registered read, with no reset. The clear engine drives its write port through a mux; the engine has priority in CLEAR.
- The top level holds the FSM, clr_cnt, range check, and response registers.

## Test plan
All scenarios use DATA_W=32, DEPTH=256.
1. Release reset → busy=1 and req_ready=0 for 256 cycles, then req_ready=1. Read 0x0010 → rdata=0x00000000, error=0.
2. Write 0xDEADBEEF to 0x0008 with wstrb=1111, then read 0x0008 → rsp_valid the cycle after the read is accepted, rdata=0xDEADBEEF. Also read 0x000B → same data (offset ignored).
3. Write 0x11223344 to 0x0008 with wstrb=0101 → read returns 0xDE22BE44.
4. Write to 0x0400 (index 256) → error=1, and index 0 is unchanged. Read 0x0400 → rdata=0, error=1. Back-to-back reads of 0x0008 and 0x0400 → rsp_valid high 2 cycles, with error 0 then 1.
5. Read 0x0008 accepted in the same cycle as clear_start → that read returns 0xDE22BE44; busy is then high for 256 cycles. Pulse clear_start again at cycle 50 → no restart. Afterwards, read 0x0008 → 0.
6. Assert reset at clear cycle 100 → all outputs go to their reset values immediately. After release, the clear lasts a full 256 cycles, and index 255 reads 0.
